// File: rtl/ddr_pkg.sv
// ---------------------------------------------------------------------------
// ddr_pkg
// Shared definitions for the DDR capture/readback blocks: default address
// width and burst step, the capture buffer upper bound, and the state
// encoding of the readback address generator.
// ---------------------------------------------------------------------------
package ddr_pkg;

    // DDR application address width and per-burst increment (BL8)
    localparam int unsigned ADDR_W_DEF    = 27;
    localparam int unsigned ADDR_STEP_DEF = 8;

    // Exclusive upper bound of the capture buffer; also used by the capture writer
    localparam int unsigned BUF_TOP_DEF   = 32'h0400_0000;

    // Readback address generator states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

endpackage

// File: rtl/ddr_rd_adx_gen_if.sv
// ---------------------------------------------------------------------------
// ddr_rd_adx_gen_if
// Control and read-address FIFO signals of the readback address generator.
//   mode, start, start_adx, burst_count : run control from the host side
//   rd_fifo_full, rd_fifo_wr_en, rd_fifo_din : read-address FIFO push port
//   rd_retire                            : one pulse per fully returned burst
//   busy, done, aborted                  : run status
// The master modport is the generator; the slave modport is its environment.
// ---------------------------------------------------------------------------
interface ddr_rd_adx_gen_if
    import ddr_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = 24
);

    logic              mode;
    logic              start;
    logic [ADDR_W-1:0] start_adx;
    logic [LEN_W-1:0]  burst_count;
    logic              rd_fifo_full;
    logic              rd_fifo_wr_en;
    logic [ADDR_W-1:0] rd_fifo_din;
    logic              rd_retire;
    logic              busy;
    logic              done;
    logic              aborted;

    modport master (
        input  mode, start, start_adx, burst_count, rd_fifo_full, rd_retire,
        output rd_fifo_wr_en, rd_fifo_din, busy, done, aborted
    );

    modport slave (
        output mode, start, start_adx, burst_count, rd_fifo_full, rd_retire,
        input  rd_fifo_wr_en, rd_fifo_din, busy, done, aborted
    );

endinterface

// File: rtl/ddr_credit_cnt.sv
// ---------------------------------------------------------------------------
// ddr_credit_cnt
// Up/down counter saturating at 0 and at MAX.
//   clk, reset : clock and synchronous active-high reset
//   inc_i      : count up by one
//   dec_i      : count down by one (ignored at 0)
//   count_o    : current count
//   at_max_o   : count equals MAX
// inc_i and dec_i together leave the count unchanged.
// ---------------------------------------------------------------------------
module ddr_credit_cnt #(
    parameter int unsigned MAX = 16,
    parameter int unsigned W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         at_max_o
);

    logic [W-1:0] count_q, count_d;

    // Next count: simultaneous inc/dec cancel; each direction saturates
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && (count_q != W'(MAX))) begin
            count_d = count_q + W'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign at_max_o = (count_q == W'(MAX));

endmodule

// File: rtl/ddr_rd_adx_gen.sv
// ---------------------------------------------------------------------------
// ddr_rd_adx_gen
// Readback address generator. On an accepted start it pushes burst_count
// burst-aligned addresses, starting at start_adx and wrapping to 0 at
// BUF_TOP, into the read-address FIFO. Pushes are throttled by FIFO full
// and by a credit counter of reads issued but not yet retired.
//   clk, reset : clock and synchronous active-high reset
//   bus        : control, FIFO and status signals (master modport)
// ---------------------------------------------------------------------------
module ddr_rd_adx_gen
    import ddr_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned ADDR_STEP = ADDR_STEP_DEF,
    parameter int unsigned BUF_TOP   = BUF_TOP_DEF,
    parameter int unsigned MAX_OUT   = 16,
    parameter int unsigned LEN_W     = 24
) (
    input  logic              clk,
    input  logic              reset,
    ddr_rd_adx_gen_if.master  bus
);

    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_adx_q, cur_adx_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic              aborted_q, aborted_d;

    logic [OUT_W-1:0]  outstanding;
    logic              credit_full;
    logic              push;
    logic [ADDR_W:0]   adx_sum;
    logic [ADDR_W-1:0] adx_next;

    // A push needs the FIFO, a free credit and bursts left; a cycle in which
    // mode is low never pushes because that cycle is spent aborting.
    assign push = (state_q == ISSUE) && bus.mode && !bus.rd_fifo_full &&
                  !credit_full && (remain_q != '0);

    // Next burst address, computed one bit wider so the wrap test cannot overflow
    always_comb begin
        adx_sum  = {1'b0, cur_adx_q} + (ADDR_W+1)'(ADDR_STEP);
        adx_next = (adx_sum >= (ADDR_W+1)'(BUF_TOP)) ? '0 : adx_sum[ADDR_W-1:0];
    end

    // Outstanding reads: up on each push, down on each retire, in every state
    ddr_credit_cnt #(
        .MAX (MAX_OUT),
        .W   (OUT_W)
    ) u_credit (
        .clk      (clk),
        .reset    (reset),
        .inc_i    (push),
        .dec_i    (bus.rd_retire),
        .count_o  (outstanding),
        .at_max_o (credit_full)
    );

    // Next-state logic. A zero-length run goes through DRAIN so that done
    // arrives two cycles after the start, like a run that has fully drained.
    always_comb begin
        state_d   = state_q;
        cur_adx_d = cur_adx_q;
        remain_d  = remain_q;
        aborted_d = aborted_q;
        case (state_q)
            IDLE: begin
                if (bus.start && bus.mode) begin
                    cur_adx_d = bus.start_adx;
                    remain_d  = bus.burst_count;
                    aborted_d = 1'b0;
                    state_d   = (bus.burst_count == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.mode) begin
                    aborted_d = 1'b1;
                    state_d   = DRAIN;
                end else if (push) begin
                    cur_adx_d = adx_next;
                    remain_d  = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (outstanding == '0) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cur_adx_q <= '0;
            remain_q  <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_adx_q <= cur_adx_d;
            remain_q  <= remain_d;
            aborted_q <= aborted_d;
        end
    end

    assign bus.rd_fifo_wr_en = push;
    assign bus.rd_fifo_din   = (state_q == ISSUE) ? cur_adx_q : '0;
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = (state_q == FIN);
    assign bus.aborted       = aborted_q;

endmodule

// File: tb/tb_ddr_rd_adx_gen.sv
// ---------------------------------------------------------------------------
// tb_ddr_rd_adx_gen
// Bench for ddr_rd_adx_gen with a 0x200-byte buffer and four credits.
// A behavioural model predicts every output each cycle; directed runs also
// pin addresses and timing to hand-computed values.
// ---------------------------------------------------------------------------
module tb_ddr_rd_adx_gen;

    localparam int unsigned ADDR_W  = 27;
    localparam int unsigned LEN_W   = 24;
    localparam int unsigned STEP    = 8;
    localparam int unsigned TOP     = 32'h200;
    localparam int unsigned MAX_OUT = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ddr_rd_adx_gen_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    ddr_rd_adx_gen #(
        .ADDR_W    (ADDR_W),
        .ADDR_STEP (STEP),
        .BUF_TOP   (TOP),
        .MAX_OUT   (MAX_OUT),
        .LEN_W     (LEN_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int nVec = 0;
    int nErr = 0;
    int cyc  = 0;

    // Observed activity, cleared at the start of every run
    logic [ADDR_W-1:0] pushLog[$];
    int                pushCyc[$];
    int                doneCnt = 0;
    int                doneCyc = 0;
    int                startCyc = 0;

    // Model of the generator in terms of run phases and counts
    bit     mIssuing = 0, mWaiting = 0, mDonePend = 0, mAborted = 0;
    int     mLeft = 0, mOut = 0;
    longint mAddr = 0;

    // Retire generation: each push is retired a fixed or random delay later
    int dueQ[$];
    bit autoRetire = 1, randLat = 0, manRetire = 0, fire;
    int retireLat = 3, lastDue = 0;

    bit                expWr, expBusy, expDone;
    logic [ADDR_W-1:0] expDin;
    int                outOld;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit mode, input bit start, input int adx,
                                 input int bc, input bit full);
        bus.mode         = mode;
        bus.start        = start;
        bus.start_adx    = ADDR_W'(adx);
        bus.burst_count  = LEN_W'(bc);
        bus.rd_fifo_full = full;
    endtask

    task automatic startRun(input int adx, input int bc);
        pushLog.delete();
        pushCyc.delete();
        applyStimulus(1'b1, 1'b1, adx, bc, 1'b0);
        startCyc = cyc;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string name);
        int base;
        int n;
        base = doneCnt;
        n = 0;
        while (doneCnt == base && n < budget) begin
            tick(1);
            n++;
        end
        nVec++;
        if (doneCnt == base) begin
            nErr++;
            $display("[TB] FAIL %s: done not seen within %0d cycles", name, budget);
        end
    endtask

    // Drive rd_retire for pushes whose delay has elapsed, plus manual pulses
    always @(posedge clk) begin
        #2;
        fire = 1'b0;
        if (dueQ.size() > 0 && dueQ[0] <= cyc) begin
            fire = 1'b1;
            void'(dueQ.pop_front());
        end
        bus.rd_retire = fire | manRetire;
    end

    // Per-cycle compare against the model, then advance the model with the
    // inputs the DUT will see at the coming rising edge
    always @(negedge clk) begin
        expBusy = mIssuing | mWaiting | mDonePend;
        expDone = mDonePend;
        expWr   = mIssuing && bus.mode && !bus.rd_fifo_full && (mOut < MAX_OUT) && (mLeft > 0);
        expDin  = mIssuing ? ADDR_W'(mAddr) : '0;
        checkOutput("wr_en",   32'(bus.rd_fifo_wr_en), 32'(expWr));
        checkOutput("din",     32'(bus.rd_fifo_din),   32'(expDin));
        checkOutput("busy",    32'(bus.busy),          32'(expBusy));
        checkOutput("done",    32'(bus.done),          32'(expDone));
        checkOutput("aborted", 32'(bus.aborted),       32'(mAborted));

        if (bus.rd_fifo_wr_en === 1'b1) begin
            pushLog.push_back(bus.rd_fifo_din);
            pushCyc.push_back(cyc);
        end
        if (bus.done === 1'b1) begin
            doneCnt++;
            doneCyc = cyc;
        end

        if (reset) begin
            dueQ.delete();
            lastDue   = 0;
            mIssuing  = 0;
            mWaiting  = 0;
            mDonePend = 0;
            mAborted  = 0;
            mLeft     = 0;
            mOut      = 0;
            mAddr     = 0;
        end else begin
            if (bus.rd_fifo_wr_en === 1'b1 && autoRetire) begin
                int d;
                d = cyc + (randLat ? int'($urandom_range(1, 6)) : retireLat);
                if (d <= lastDue) d = lastDue + 1;
                lastDue = d;
                dueQ.push_back(d);
            end
            outOld = mOut;
            if (mDonePend) begin
                mDonePend = 0;
            end else if (mWaiting) begin
                if (outOld == 0) begin
                    mWaiting  = 0;
                    mDonePend = 1;
                end
            end else if (mIssuing) begin
                if (!bus.mode) begin
                    mIssuing = 0;
                    mWaiting = 1;
                    mAborted = 1;
                end else if (expWr) begin
                    mLeft--;
                    mAddr = (mAddr + STEP >= TOP) ? 0 : mAddr + STEP;
                    if (mLeft == 0) begin
                        mIssuing = 0;
                        mWaiting = 1;
                    end
                end
            end else if (bus.start && bus.mode) begin
                mAddr    = longint'(bus.start_adx);
                mLeft    = int'(bus.burst_count);
                mAborted = 0;
                if (mLeft == 0) mWaiting = 1;
                else            mIssuing = 1;
            end
            if (expWr && !bus.rd_retire) mOut++;
            else if (bus.rd_retire && !expWr && mOut > 0) mOut--;
        end
    end

    initial begin
        int n;
        int m;
        int base;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
        tick(3);

        // Reset state
        checkOutput("reset.wr_en",   32'(bus.rd_fifo_wr_en), 0);
        checkOutput("reset.din",     32'(bus.rd_fifo_din),   0);
        checkOutput("reset.busy",    32'(bus.busy),          0);
        checkOutput("reset.done",    32'(bus.done),          0);
        checkOutput("reset.aborted", 32'(bus.aborted),       0);
        reset = 1'b0;
        tick(2);

        // Start with mode low is ignored
        pushLog.delete();
        applyStimulus(1'b0, 1'b1, 'h100, 4, 1'b0);
        tick(1);
        bus.start = 1'b0;
        tick(3);
        checkOutput("nomode.busy",   32'(bus.busy), 0);
        checkOutput("nomode.pushes", pushLog.size(), 0);

        // Basic run, retire three cycles after each push
        startRun('h100, 4);
        n = startCyc;
        base = doneCnt;
        waitDone(40, "basic.wait");
        checkOutput("basic.count", pushLog.size(), 4);
        checkOutput("basic.a0", 32'(pushLog[0]), 'h100);
        checkOutput("basic.a1", 32'(pushLog[1]), 'h108);
        checkOutput("basic.a2", 32'(pushLog[2]), 'h110);
        checkOutput("basic.a3", 32'(pushLog[3]), 'h118);
        checkOutput("basic.firstCyc", pushCyc[0], n + 1);
        checkOutput("basic.lastCyc",  pushCyc[3], n + 4);
        checkOutput("basic.doneCyc",  doneCyc,    n + 9);
        checkOutput("basic.busyLow",  32'(bus.busy),    0);
        checkOutput("basic.aborted",  32'(bus.aborted), 0);
        tick(2);
        checkOutput("basic.doneOnce", doneCnt - base, 1);

        // Wrap at the buffer top
        startRun('h1F0, 4);
        waitDone(40, "wrap.wait");
        checkOutput("wrap.count", pushLog.size(), 4);
        checkOutput("wrap.a0", 32'(pushLog[0]), 'h1F0);
        checkOutput("wrap.a1", 32'(pushLog[1]), 'h1F8);
        checkOutput("wrap.a2", 32'(pushLog[2]), 'h000);
        checkOutput("wrap.a3", 32'(pushLog[3]), 'h008);

        // Zero-length run
        startRun('h80, 0);
        n = startCyc;
        waitDone(10, "zero.wait");
        checkOutput("zero.doneCyc", doneCyc, n + 2);
        checkOutput("zero.pushes",  pushLog.size(), 0);

        // Credit limit: four pushes, stall, one retire releases one push
        autoRetire = 0;
        startRun('h40, 6);
        n = startCyc;
        tick(10);
        checkOutput("credit.stallCount", pushLog.size(), 4);
        checkOutput("credit.lastCyc",    pushCyc[3], n + 4);
        manRetire = 1;
        m = cyc;
        tick(1);
        manRetire = 0;
        tick(3);
        checkOutput("credit.oneMore",    pushLog.size(), 5);
        checkOutput("credit.releaseCyc", pushCyc[4], m + 1);
        manRetire = 1;
        waitDone(40, "credit.wait");
        manRetire = 0;
        checkOutput("credit.total", pushLog.size(), 6);
        checkOutput("credit.last",  32'(pushLog[5]), 'h68);
        autoRetire = 1;
        tick(2);

        // FIFO backpressure for three cycles after the first push
        retireLat = 2;
        startRun('h0, 6);
        n = startCyc;
        tick(1);
        bus.rd_fifo_full = 1'b1;
        tick(3);
        bus.rd_fifo_full = 1'b0;
        waitDone(40, "bp.wait");
        checkOutput("bp.count",     pushLog.size(), 6);
        checkOutput("bp.firstCyc",  pushCyc[0], n + 1);
        checkOutput("bp.resumeCyc", pushCyc[1], n + 5);
        checkOutput("bp.a1",        32'(pushLog[1]), 'h08);
        checkOutput("bp.a5",        32'(pushLog[5]), 'h28);

        // Abort after two pushes
        retireLat = 4;
        startRun('h100, 8);
        n = startCyc;
        tick(2);
        bus.mode = 1'b0;
        waitDone(30, "abort.wait");
        checkOutput("abort.count",   pushLog.size(), 2);
        checkOutput("abort.doneCyc", doneCyc, n + 8);
        checkOutput("abort.flag",    32'(bus.aborted), 1);
        tick(3);
        checkOutput("abort.held",    32'(bus.aborted), 1);

        // Reset in the middle of ISSUE; the new start also clears aborted
        retireLat = 3;
        startRun('h0, 10);
        checkOutput("restart.abortClr", 32'(bus.aborted), 0);
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checkOutput("midreset.wr_en", 32'(bus.rd_fifo_wr_en), 0);
        checkOutput("midreset.din",   32'(bus.rd_fifo_din),   0);
        checkOutput("midreset.busy",  32'(bus.busy),          0);
        checkOutput("midreset.done",  32'(bus.done),          0);
        tick(3);
        checkOutput("midreset.pushes", pushLog.size(), 2);
        checkOutput("midreset.idle",   32'(bus.busy),  0);

        // Randomized runs: backpressure, random retire delay, aborts, stray starts
        randLat = 1;
        for (int r = 0; r < 40; r++) begin
            int adx, bc, abortAt, k;
            bit doAbort;
            adx     = int'($urandom_range(0, TOP / STEP - 1)) * STEP;
            bc      = int'($urandom_range(0, 10));
            doAbort = ($urandom_range(0, 3) == 0);
            abortAt = int'($urandom_range(1, 8));
            base    = doneCnt;
            startRun(adx, bc);
            k = 0;
            while (doneCnt == base && k < 200) begin
                bus.rd_fifo_full = ($urandom_range(0, 3) == 0);
                if (doAbort && k == abortAt) bus.mode = 1'b0;
                bus.start       = ($urandom_range(0, 7) == 0);
                bus.start_adx   = ADDR_W'($urandom_range(0, TOP / STEP - 1) * STEP);
                bus.burst_count = LEN_W'($urandom_range(0, 10));
                tick(1);
                k++;
            end
            bus.start        = 1'b0;
            bus.rd_fifo_full = 1'b0;
            nVec++;
            if (doneCnt == base) begin
                nErr++;
                $display("[TB] FAIL random.run%0d: done not seen within 200 cycles", r);
            end
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
